// File: rtl/ex_operand2_if.sv
// Bundles the operand-2 request, forwarding, stall/flush and registered result
// signals of the EX-stage operand-2 unit. The master side issues requests and
// observes results. The slave side is the unit itself.
interface ex_operand2_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
);
  logic                    in_valid;
  logic [1:0]              in_sel;
  logic [4:0]              in_rs2;
  logic [XLEN-1:0]         in_rs2_data;
  logic [XLEN-1:0]         in_imm;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [5*NUM_FWD-1:0]    fwd_rd;
  logic [XLEN*NUM_FWD-1:0] fwd_data;
  logic [NUM_FWD-1:0]      fwd_pending;
  logic                    stall;
  logic                    flush;
  logic                    hazard_stall;
  logic                    out_valid;
  logic [XLEN-1:0]         out_op2;
  logic [NUM_FWD-1:0]      out_fwd_hit;
  logic                    out_illegal;
  logic [CNT_W-1:0]        fwd_count;

  modport master (
    output in_valid, in_sel, in_rs2, in_rs2_data, in_imm,
    output fwd_valid, fwd_rd, fwd_data, fwd_pending, stall, flush,
    input  hazard_stall, out_valid, out_op2, out_fwd_hit, out_illegal, fwd_count
  );

  modport slave (
    input  in_valid, in_sel, in_rs2, in_rs2_data, in_imm,
    input  fwd_valid, fwd_rd, fwd_data, fwd_pending, stall, flush,
    output hazard_stall, out_valid, out_op2, out_fwd_hit, out_illegal, fwd_count
  );
endinterface

// File: rtl/ex_operand2_unit.sv
// EX-stage operand-2 unit. It selects the ALU second operand from the register
// file, the immediate or a constant, and applies fixed-priority forwarding
// (source 0 is youngest). It raises a combinational load-use hazard and
// registers the result with stall/flush control. It also keeps a saturating
// count of forwarded operands.
module ex_operand2_unit #(
  parameter int          XLEN      = 32,
  parameter int          NUM_FWD   = 2,
  parameter int unsigned CONST_VAL = 4,
  parameter int          CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_operand2_if.slave    bus
);

  typedef enum logic [1:0] {
    SEL_REG   = 2'b00,
    SEL_IMM   = 2'b01,
    SEL_CONST = 2'b10,
    SEL_ILL   = 2'b11
  } sel_e;

  localparam logic [XLEN-1:0] CONST_OP = XLEN'(CONST_VAL);

  sel_e               sel;
  logic [NUM_FWD-1:0] win_hit;
  logic               win_found;
  logic [XLEN-1:0]    win_data;
  logic               win_pending;

  logic [XLEN-1:0]    sel_op;
  logic [NUM_FWD-1:0] sel_hit;
  logic               sel_illegal;
  logic               fwd_used;

  logic               out_valid_q;
  logic [XLEN-1:0]    out_op2_q;
  logic [NUM_FWD-1:0] out_fwd_hit_q;
  logic               out_illegal_q;
  logic [CNT_W-1:0]   fwd_count_q;

  assign sel = sel_e'(bus.in_sel);

  // Fixed-priority search for the youngest source writing rs2; x0 never forwards.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    win_hit     = '0;
    win_found   = 1'b0;
    win_data    = '0;
    win_pending = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!win_found && bus.fwd_valid[i] &&
          (bus.fwd_rd[5*i +: 5] == bus.in_rs2) && (bus.in_rs2 != 5'd0)) begin
        win_hit[i]  = 1'b1;
        win_found   = 1'b1;
        win_data    = bus.fwd_data[XLEN*i +: XLEN];
        win_pending = bus.fwd_pending[i];
      end
    end
  end

  // Operand mux by source select; only the register path can use forwarding.
  always_comb begin
    sel_op      = '0;
    sel_hit     = '0;
    sel_illegal = 1'b0;
    case (sel)
      SEL_REG: begin
        sel_op  = win_found ? win_data : bus.in_rs2_data;
        sel_hit = win_hit;
      end
      SEL_IMM:   sel_op = bus.in_imm;
      SEL_CONST: sel_op = CONST_OP;
      default:   sel_illegal = 1'b1;
    endcase
  end

  // A pending result only matters if it belongs to the winning source of a register read.
  assign fwd_used         = bus.in_valid && (sel == SEL_REG) && win_found;
  assign bus.hazard_stall = fwd_used && win_pending && !bus.flush;

  // One-entry output stage: flush beats stall, stall beats hazard bubble, else load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_op2_q     <= '0;
      out_fwd_hit_q <= '0;
      out_illegal_q <= 1'b0;
      fwd_count_q   <= '0;
    end else if (bus.flush) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      out_valid_q   <= 1'b0;
      out_op2_q     <= '0;
      out_fwd_hit_q <= '0;
      out_illegal_q <= 1'b0;
    end else if (bus.stall) begin
      out_valid_q   <= out_valid_q;
    end else if (bus.hazard_stall) begin
      out_valid_q   <= 1'b0;
      out_fwd_hit_q <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_op2_q     <= sel_op;
        out_fwd_hit_q <= sel_hit;
        out_illegal_q <= sel_illegal;
      end else begin
        out_op2_q     <= '0;
        out_fwd_hit_q <= '0;
        out_illegal_q <= 1'b0;
      end
      if (fwd_used && (fwd_count_q != '1)) begin
        fwd_count_q <= fwd_count_q + 1'b1;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_op2     = out_op2_q;
  assign bus.out_fwd_hit = out_fwd_hit_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.fwd_count   = fwd_count_q;

endmodule

// File: doc/ex_operand2_unit.md
# ex_operand2_unit

Parametrised EX-stage operand-2 unit for the rv32 core pipeline. Selects the ALU second operand from the register-file value, the immediate, or a fixed constant, and applies operand forwarding from up to NUM_FWD younger pipeline stages with fixed priority. It detects load-use hazards and registers the result into a one-entry output stage with stall/flush control. It also keeps a saturating count of forwarded operands for performance monitoring.

## Interface
Parameters:
- XLEN, 32, operand width
- NUM_FWD, 2, number of forwarding sources; index 0 is youngest and highest priority
- CONST_VAL, 4, constant selected by sel 2'b10
- CNT_W, 16, forward-hit counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand request valid
- in_sel  in  2  source: 00 register/forward, 01 immediate, 10 CONST_VAL, 11 illegal
- in_rs2  in  5  source register index
- in_rs2_data  in  XLEN  register-file read value
- in_imm  in  XLEN  decoded immediate
- fwd_valid  in  NUM_FWD  forwarding source i writes a register
- fwd_rd  in  5*NUM_FWD  destination index of source i, slice [5i+4:5i]
- fwd_data  in  XLEN*NUM_FWD  result of source i
- fwd_pending  in  NUM_FWD  source i result not yet available (load in flight)
- stall  in  1  downstream hold
- flush  in  1  kill the output stage
- hazard_stall  out  1  combinational; upstream must hold the current request
- out_valid  out  1  registered operand valid
- out_op2  out  XLEN  registered operand
- out_fwd_hit  out  NUM_FWD  one-hot forwarding source used; all-zero if none
- out_illegal  out  1  registered; in_sel was 11
- fwd_count  out  CNT_W  saturating count of forwarded operands

## Operation
- Match i: fwd_valid[i] & fwd_rd[i]==in_rs2 & in_rs2!=0. The winner is the lowest matching i. Register x0 is never forwarded.
- When in_sel==00: operand = fwd_data[winner] if there is a winner, else in_rs2_data. out_fwd_hit is one-hot on the winner.
- When in_sel==01: operand = in_imm. When in_sel==10: operand = CONST_VAL, zero-extended to XLEN. In both cases out_fwd_hit=0.
- When in_sel==11: operand = 0, out_illegal=1, out_fwd_hit=0.
- hazard_stall = in_valid & in_sel==00 & winner exists & fwd_pending[winner] & ~flush.
  - A pending non-winning source is ignored.
  - fwd_pending is ignored when in_sel!=00.
- Update rules at each rising edge, in priority order:
  - flush: out_valid=0, out_op2=0, out_fwd_hit=0, out_illegal=0.
  - else stall: all outputs hold, including fwd_count.
  - else hazard_stall: bubble. out_valid=0, out_fwd_hit=0, out_illegal=0; out_op2 holds.
  - else: out_valid=in_valid and the remaining outputs load the selected values. When in_valid=0, out_op2, out_fwd_hit and out_illegal load 0.
- fwd_count increments by 1 on a load with in_valid=1 and a forwarding winner used. It saturates at all-ones and is cleared only by reset.

## Timing
- Reset (asynchronous assertion, synchronous release): out_valid=0, out_op2=0, out_fwd_hit=0, out_illegal=0, fwd_count=0.
- Latency: a request is visible on the outputs 1 cycle after a non-stalled, non-hazard edge.
- hazard_stall is purely combinational in the same cycle. The request must be held stable until hazard_stall drops; the operand loads on that edge.
- stall and hazard_stall together: stall wins and outputs hold.
- flush together with stall: flush wins.
- Reset asserted mid-stall or mid-hazard: outputs clear immediately and no request is retained.

## Test plan
- Reset with rst_n=0 mid-cycle -> all outputs 0 immediately, fwd_count=0.
- Select sweep with no forwarding: sel=00 with in_rs2_data=0x11, then 01 with in_imm=0xFFFFF800, then 10, then 11 -> outputs 0x11, 0xFFFFF800, 0x4, then 0 with out_illegal=1. Each output appears one cycle later.
- Priority: rs2=5, both sources write x5 with data 0xAA (src0) and 0xBB (src1) -> out_op2=0xAA, out_fwd_hit=01, fwd_count=1. Repeat with rs2=0 -> in_rs2_data used, fwd_hit=00.
- Load-use: src0 matches with fwd_pending[0]=1 for 2 cycles -> hazard_stall=1 and out_valid=0 for those 2 cycles. After pending drops, out_op2=fwd_data[0] on the next edge.
- Stall/flush: stall=1 for 3 cycles -> outputs hold. stall=1 and flush=1 together -> out_valid=0 and out_op2=0.
- Saturation: with CNT_W=2, 5 forwarded requests -> fwd_count=3.
